// File: rtl/rgb_to_gray_pipe.sv
// Three-stage RGB-to-luma converter with matched sync delay and a per-frame
// active-pixel counter used to check frame completeness.
module rgb_to_gray_pipe #(
  parameter logic [7:0] KR    = 8'd77,
  parameter logic [7:0] KG    = 8'd150,
  parameter logic [7:0] KB    = 8'd29,
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bypass,
  input  logic [7:0]       red_i,
  input  logic [7:0]       green_i,
  input  logic [7:0]       blue_i,
  input  logic             dv_i,
  input  logic             hs_i,
  input  logic             vs_i,
  output logic [7:0]       red_o,
  output logic [7:0]       green_o,
  output logic [7:0]       blue_o,
  output logic             dv_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic             frame_done_o
);

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

  // Stage 1: products plus the raw pixel and its side-band bits
  logic [15:0]      pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic [23:0]      rgb1_q, rgb1_d;
  logic             dv1_q, dv1_d, hs1_q, hs1_d, vs1_q, vs1_d, byp1_q, byp1_d;
  // Stage 2: rounded sum
  logic [17:0]      sum_q, sum_d;
  logic [23:0]      rgb2_q, rgb2_d;
  logic             dv2_q, dv2_d, hs2_q, hs2_d, vs2_q, vs2_d, byp2_q, byp2_d;
  // Stage 3: output registers
  logic [7:0]       r3_q, r3_d, g3_q, g3_d, b3_q, b3_d;
  logic             dv3_q, dv3_d, hs3_q, hs3_d, vs3_q, vs3_d;
  // Frame counter
  logic             vs_o_q, vs_o_d;
  logic [CNT_W-1:0] acc_q, acc_d, pix_cnt_q, pix_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic [9:0]       y_wide;
  logic [7:0]       y_sat;
  logic             vs_rise;

  always_comb begin
    pr_d = pr_q;  pg_d = pg_q;  pb_d = pb_q;  rgb1_d = rgb1_q;
    dv1_d = dv1_q;  hs1_d = hs1_q;  vs1_d = vs1_q;  byp1_d = byp1_q;
    sum_d = sum_q;  rgb2_d = rgb2_q;
    dv2_d = dv2_q;  hs2_d = hs2_q;  vs2_d = vs2_q;  byp2_d = byp2_q;
    r3_d = r3_q;  g3_d = g3_q;  b3_d = b3_q;
    dv3_d = dv3_q;  hs3_d = hs3_q;  vs3_d = vs3_q;
    vs_o_d = vs_o_q;  acc_d = acc_q;  pix_cnt_d = pix_cnt_q;
    frame_done_d = frame_done_q;

    y_wide  = sum_q[17:8];
    y_sat   = (y_wide > 10'd255) ? 8'hFF : y_wide[7:0];
    vs_rise = vs3_q & ~vs_o_q;

    if (en) begin
      pr_d   = 16'(KR) * 16'(red_i);
      pg_d   = 16'(KG) * 16'(green_i);
      pb_d   = 16'(KB) * 16'(blue_i);
      rgb1_d = {red_i, green_i, blue_i};
      dv1_d  = dv_i;
      hs1_d  = hs_i;
      vs1_d  = vs_i;
      byp1_d = bypass;

      sum_d  = 18'(pr_q) + 18'(pg_q) + 18'(pb_q) + 18'd128;
      rgb2_d = rgb1_q;
      dv2_d  = dv1_q;
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      byp2_d = byp1_q;

      // Blanked pixels drive black; bypass selects the untouched pixel
      if (!dv2_q) begin
        r3_d = 8'd0;  g3_d = 8'd0;  b3_d = 8'd0;
      end else if (byp2_q) begin
        r3_d = rgb2_q[23:16];  g3_d = rgb2_q[15:8];  b3_d = rgb2_q[7:0];
      end else begin
        r3_d = y_sat;  g3_d = y_sat;  b3_d = y_sat;
      end
      dv3_d = dv2_q;
      hs3_d = hs2_q;
      vs3_d = vs2_q;

      vs_o_d = vs3_q;
      // A pixel coincident with the vs rise belongs to the new frame
      if (vs_rise) begin
        pix_cnt_d    = acc_q;
        acc_d        = dv3_q ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        frame_done_d = 1'b1;
      end else begin
        frame_done_d = 1'b0;
        if (dv3_q && (acc_q != ACC_MAX)) begin
          acc_d = acc_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          acc_d = acc_q;
        end
      end
    end else begin
      frame_done_d = frame_done_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q <= '0;  pg_q <= '0;  pb_q <= '0;  rgb1_q <= '0;
      dv1_q <= 1'b0;  hs1_q <= 1'b0;  vs1_q <= 1'b0;  byp1_q <= 1'b0;
      sum_q <= '0;  rgb2_q <= '0;
      dv2_q <= 1'b0;  hs2_q <= 1'b0;  vs2_q <= 1'b0;  byp2_q <= 1'b0;
      r3_q <= '0;  g3_q <= '0;  b3_q <= '0;
      dv3_q <= 1'b0;  hs3_q <= 1'b0;  vs3_q <= 1'b0;
      vs_o_q <= 1'b0;  acc_q <= '0;  pix_cnt_q <= '0;  frame_done_q <= 1'b0;
    end else begin
      pr_q <= pr_d;  pg_q <= pg_d;  pb_q <= pb_d;  rgb1_q <= rgb1_d;
      dv1_q <= dv1_d;  hs1_q <= hs1_d;  vs1_q <= vs1_d;  byp1_q <= byp1_d;
      sum_q <= sum_d;  rgb2_q <= rgb2_d;
      dv2_q <= dv2_d;  hs2_q <= hs2_d;  vs2_q <= vs2_d;  byp2_q <= byp2_d;
      r3_q <= r3_d;  g3_q <= g3_d;  b3_q <= b3_d;
      dv3_q <= dv3_d;  hs3_q <= hs3_d;  vs3_q <= vs3_d;
      vs_o_q <= vs_o_d;  acc_q <= acc_d;  pix_cnt_q <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign red_o        = r3_q;
  assign green_o      = g3_q;
  assign blue_o       = b3_q;
  assign dv_o         = dv3_q;
  assign hs_o         = hs3_q;
  assign vs_o         = vs3_q;
  assign pix_cnt_o    = pix_cnt_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Scoreboard bench for rgb_to_gray_pipe: stimulus pushes expected pixels and
// frame counts from a plain-arithmetic model; a monitor pops and compares.
module tb_rgb_to_gray_pipe;
  localparam int CNT_W = 21;

  logic clk = 1'b0;
  logic rst, en, bypass, dv_i, hs_i, vs_i;
  logic [7:0] red_i, green_i, blue_i, red_o, green_o, blue_o;
  logic dv_o, hs_o, vs_o, frame_done_o;
  logic [CNT_W-1:0] pix_cnt_o;

  rgb_to_gray_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .bypass(bypass),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .pix_cnt_o(pix_cnt_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic dv, hs, vs;
  } exp_t;

  exp_t        pq[$];
  int unsigned fq[$];
  exp_t        last;
  int          n_vec = 0, n_err = 0;
  logic        en_s = 1'b0;
  int unsigned cnt;
  logic        prev_vs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic byp, input logic [7:0] r, g, b,
                                 input logic dv, hs, vs);
    exp_t e;
    int y;
    y = (77 * int'(r) + 150 * int'(g) + 29 * int'(b) + 128) / 256;
    if (y > 255) y = 255;
    e.dv = dv; e.hs = hs; e.vs = vs;
    if (!dv) begin
      e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
    end else if (byp) begin
      e.r = r; e.g = g; e.b = b;
    end else begin
      e.r = 8'(y); e.g = 8'(y); e.b = 8'(y);
    end
    return e;
  endfunction

  task automatic drive(input logic e, byp, input logic [7:0] r, g, b,
                       input logic dv, hs, vs);
    @(posedge clk); #2;
    en = e; bypass = byp; red_i = r; green_i = g; blue_i = b;
    dv_i = dv; hs_i = hs; vs_i = vs;
    if (e) begin
      pq.push_back(model(byp, r, g, b, dv, hs, vs));
      if (vs && !prev_vs) begin
        fq.push_back(cnt);
        cnt = 0;
      end
      if (dv) cnt++;
      prev_vs = vs;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic zero_inputs();
    en = 1'b0; bypass = 1'b0; red_i = 8'd0; green_i = 8'd0; blue_i = 8'd0;
    dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    pq.delete(); fq.delete();
    last = '0;
    pq.push_back('0);
    pq.push_back('0);
    cnt = 0; prev_vs = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_pix"}, 64'({red_o, green_o, blue_o, dv_o, hs_o, vs_o}), 64'd0);
    chk({name, "_cnt"}, 64'({pix_cnt_o, frame_done_o}), 64'd0);
  endtask

  // Monitor: pops one expected pixel per enabled edge, checks freeze otherwise
  always @(posedge clk) en_s = en;

  always @(negedge clk) begin
    if (!rst) begin
      if (en_s) begin
        if (pq.size() == 0) begin
          chk("pix_queue_underflow", 64'd1, 64'd0);
        end else begin
          last = pq.pop_front();
          chk("pix", 64'({red_o, green_o, blue_o, dv_o, hs_o, vs_o}), 64'(last));
        end
        if (frame_done_o) begin
          if (fq.size() == 0) chk("frame_done_unexpected", 64'd1, 64'd0);
          else chk("pix_cnt", 64'(pix_cnt_o), 64'(fq.pop_front()));
        end
      end else begin
        chk("stall_freeze", 64'({red_o, green_o, blue_o, dv_o, hs_o, vs_o}), 64'(last));
      end
    end
  end

  initial begin
    rst = 1'b1;
    zero_inputs();
    last = '0; cnt = 0; prev_vs = 1'b0;
    #3;
    check_reset_outputs("reset_init");
    release_reset();

    // Grey 200 with 3-edge latency
    drive(1'b1, 1'b0, 8'd200, 8'd200, 8'd200, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Primaries on consecutive cycles
    drive(1'b1, 1'b0, 8'd255, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 8'd255, 8'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd255, 1'b1, 1'b0, 1'b0);
    // Bypass then convert the same pixel
    drive(1'b1, 1'b1, 8'd10, 8'd20, 8'd30, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd10, 8'd20, 8'd30, 1'b1, 1'b0, 1'b0);
    // Blanked data with a 2-cycle hsync pulse
    drive(1'b1, 1'b0, 8'd100, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'd100, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Open a frame, then four 4-pixel lines with a stall mid-line, then vsync
    drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(3);
    for (int ln = 0; ln < 4; ln++) begin
      for (int px = 0; px < 4; px++) begin
        drive(1'b1, 1'(px & 1), 8'(ln * 40 + px), 8'(px * 60), 8'(255 - ln), 1'b1, 1'b0, 1'b0);
        if (ln == 1 && px == 1) begin
          for (int s = 0; s < 5; s++)
            drive(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1);
        end
      end
      drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      idle(2);
    end
    drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(6);

    // Asynchronous reset mid-line with pixels in flight
    for (int px = 0; px < 5; px++)
      drive(1'b1, 1'b0, 8'(px * 50), 8'd90, 8'd33, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    zero_inputs();
    #1;
    check_reset_outputs("reset_async");
    release_reset();
    for (int px = 0; px < 6; px++)
      drive(1'b1, 1'b0, 8'(px * 31), 8'(px * 17), 8'(px * 5), 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(6);

    // Randomized traffic with periodic vsync pulses
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
            1'((i % 211) < 3));
    end
    idle(8);

    chk("frame_queue_empty", 64'(fq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray_pipe.md
Name: rgb_to_gray_pipe

Overview:
Pixel-processing stage between the VGA timing/pixel source and the regression tester.
Converts each active 8-bit RGB pixel to luma, Y = (KR*R + KG*G + KB*B + 128) >> 8, in a fixed 3-stage pipeline.
Y is driven on all three output channels; dv/hs/vs are delayed to match.
It also counts active output pixels per frame, for checking frame completeness against HRES*VRES.

Parameters:
KR, 77, red coefficient (8-bit unsigned)
KG, 150, green coefficient (8-bit unsigned)
KB, 29, blue coefficient (8-bit unsigned)
CNT_W, 21, width of the pixel counter (fits 1600*900 = 1,440,000)

Ports:
clk  input  1  pixel clock
rst  input  1  reset, asynchronous, active-high
en  input  1  clock enable; all pipeline and counter registers hold while low
bypass  input  1  1: pass RGB through unconverted (sampled with the pixel)
red_i  input  8  red in
green_i  input  8  green in
blue_i  input  8  blue in
dv_i  input  1  data valid in
hs_i  input  1  hsync in
vs_i  input  1  vsync in
red_o  output  8  Y, or red when bypassed
green_o  output  8  Y, or green when bypassed
blue_o  output  8  Y, or blue when bypassed
dv_o  output  1  dv_i delayed 3 cycles
hs_o  output  1  hs_i delayed 3 cycles
vs_o  output  1  vs_i delayed 3 cycles
pix_cnt_o  output  CNT_W  active pixels counted in the last completed frame
frame_done_o  output  1  one-cycle pulse when pix_cnt_o updates

Behaviour:
- Reset: every pipeline register, every output, the accumulator and the vs edge register go to 0 immediately; no clock is required.
- Latency: an input sampled at enabled edge N appears on the outputs after enabled edge N+2, i.e. 3 enabled edges. Pixel data and sync always stay aligned.
- Stage 1: register the products pr=KR*R, pg=KG*G, pb=KB*B (16-bit each), plus dv, hs, vs, bypass and the raw RGB.
- Stage 2: sum = pr + pg + pb + 128, 18-bit unsigned, no overflow.
- Stage 3: Y = sum[17:8], saturated to 255 if greater than 255.
  - Output is RGB = Y,Y,Y, or the raw RGB if bypass was 1 at stage 1.
  - Saturation cannot occur with the default coefficients (max sum 65408) but is still required.
- Blanking: when the stage-3 dv is 0, red_o/green_o/blue_o are 0 regardless of input. Sync outputs are passed through unchanged, polarity preserved.
- en=0: no register changes, outputs frozen; frame_done_o stays at its current value, so it is gated by en.
- Counter:
  - acc increments by 1 on each enabled edge where the stage-3 dv (the next dv_o) is 1.
  - acc saturates at 2^CNT_W-1.
- Frame edge: vs_o_q is vs_o registered.
  - A rising edge (vs_o=1, vs_o_q=0) on an enabled edge loads pix_cnt_o <= acc and clears acc to 0.
  - frame_done_o=1 for exactly that one cycle, otherwise 0.
  - If dv_o=1 in the same cycle as a vs rise, that pixel counts toward the new frame: acc <= 1.
- Reset mid-frame discards the partial count. The first frame_done_o after reset reports only pixels seen since reset.
- bypass may toggle every cycle; each pixel uses its own sampled value.

Test Plan:
1. R=G=B=200, dv=1, bypass=0 → RGB_o=200,200,200 exactly 3 cycles later; dv_o rises 3 cycles after dv_i.
2. Pixel sequence (255,0,0), (0,255,0), (0,0,255) on consecutive cycles → Y = 77, 149, 29 on consecutive cycles starting at cycle 3.
3. bypass=1 with (10,20,30), then bypass=0 with (10,20,30) next cycle → outputs (10,20,30), then (18,18,18).
4. dv_i=0 with R=100, hs_i pulse of 2 cycles → RGB_o=0; hs_o is the same 2-cycle pulse delayed 3 cycles.
5. Four lines of 4 active pixels, blanking between lines, then a vs_i pulse; stall en=0 for 5 cycles mid-line → outputs frozen during the stall; pix_cnt_o=16 with a single frame_done_o pulse, 1 cycle after vs_o rises.
6. Assert rst asynchronously mid-line while dv_o=1 → all outputs 0 before the next clock edge; after release, the next frame of 6 pixels reports pix_cnt_o=6.
